// File: rtl/keyboard_event_queue_if.sv
// Event handshake between a key-event producer and keyboard_event_queue.
// The producer holds ev_valid/ev_press/ev_code until ev_ready is seen on an edge.
interface keyboard_event_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_press;
  logic [7:0] ev_code;

  modport master (
    output ev_valid,
    output ev_press,
    output ev_code,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_press,
    input  ev_code,
    output ev_ready
  );
endinterface

// File: rtl/keyboard_event_queue.sv
// keyboard_event_queue: buffers key press/release events in a small FIFO and
// presents the currently held key code as the 16-bit memory-mapped keyboard
// word. A loaded code stays visible until its hold counter reaches HOLD_CYCLES,
// so a short keystroke is never missed by a polling program.
// Optional build macro KBD_OVF_EN adds a sticky drop flag (ovf) with clear (ovf_clr).
module keyboard_event_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  keyboard_event_queue_if.slave ev,
  output logic [15:0]           key_out
`ifdef KBD_OVF_EN
  ,
  output logic                  ovf,
  input  logic                  ovf_clr
`endif
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned HW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  typedef enum logic {IDLE, HELD} state_t;

  // FIFO storage: {press, code} per entry
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop;
  logic          head_press;
  logic [7:0]    head_code;

  // Held-key state
  state_t        state, state_n;
  logic [7:0]    cur, cur_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          hold_met;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign ev.ev_ready = !full;
  assign push        = ev.ev_valid && !full;
  assign head_press  = mem[rptr][8];
  assign head_code   = mem[rptr][7:0];
  assign hold_met    = (hcnt == HOLD_MAX);

  // FIFO data array; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {ev.ev_press, ev.ev_code};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Held-key state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur   <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      hcnt  <= hcnt_n;
    end
  end

  // Head-of-queue decision: at most one pop per cycle, a waiting head blocks the queue
  always_comb begin
    state_n = state;
    cur_n   = cur;
    hcnt_n  = hcnt;
    pop     = 1'b0;
    if (state == HELD && !hold_met) begin
      hcnt_n = hcnt + HW'(1);
    end
    if (!empty) begin
      case (state)
        IDLE: begin
          pop = 1'b1;
          if (head_press) begin
            cur_n   = head_code;
            hcnt_n  = '0;
            state_n = HELD;
          end
        end
        HELD: begin
          if (head_press) begin
            if (head_code == cur) begin
              pop = 1'b1;
            end else if (hold_met) begin
              pop    = 1'b1;
              cur_n  = head_code;
              hcnt_n = '0;
            end
          end else begin
            if (head_code != cur) begin
              pop = 1'b1;
            end else if (hold_met) begin
              pop     = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Keyboard word seen by the CPU
  always_comb begin
    key_out = '0;
    if (state == HELD) begin
      key_out = {8'h00, cur};
    end
  end

`ifdef KBD_OVF_EN
  // Sticky drop flag: a stalled offer sets it, and setting wins over clearing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ev.ev_valid && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Self-checking bench for keyboard_event_queue (DEPTH=4, HOLD_CYCLES=16).
module tb_keyboard_event_queue;

  localparam int unsigned HOLD = 16;

  logic        clk;
  logic        reset;
  logic [15:0] key_out;
`ifdef KBD_OVF_EN
  logic        ovf;
  logic        ovf_clr;
`endif

  keyboard_event_queue_if bus ();

  keyboard_event_queue #(
    .DEPTH       (4),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ev      (bus),
    .key_out (key_out)
`ifdef KBD_OVF_EN
    ,
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    logic        v;
    logic        p;
    logic [7:0]  c;
    logic [15:0] k;
    logic        r;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic drive(input logic v, input logic p, input logic [7:0] c);
    bus.ev_valid = v;
    bus.ev_press = p;
    bus.ev_code  = c;
  endtask

  // Offer one event for exactly one edge (caller knows the FIFO has room)
  task automatic push(input logic p, input logic [7:0] c);
    drive(1'b1, p, c);
    tick();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // Idle until the given edge, checking key_out after every edge
  task automatic idle_until(input int target, input logic [15:0] exp, input string name);
    while (edge_n < target) begin
      tick();
      check(name, key_out, exp);
    end
  endtask

  int load_e;
  int load2_e;
  int acc_e;
  logic acc;
  logic [7:0] ev5_code [5];
  logic       ev5_press [5];
  int         ev5_exp [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h42, 16'h0000, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h41, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 16'h0041, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 16'h0041, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'h41, 16'h0041, 1'b1};

    drive(1'b0, 1'b0, 8'h00);
`ifdef KBD_OVF_EN
    ovf_clr = 1'b0;
`endif
    reset = 1'b1;
    tick();
    tick();
    check("reset_key", key_out, 16'h0000);
    check("reset_ready", {15'd0, bus.ev_ready}, 16'h0001);
`ifdef KBD_OVF_EN
    check("reset_ovf", {15'd0, ovf}, 16'h0000);
`endif
    #2 reset = 1'b0;

    // Release in IDLE is discarded; then press 0x41 and release it
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].p, vecs[i].c);
      tick();
      if (i == 4) load_e = edge_n;
      check($sformatf("vec%0d_key", i), key_out, vecs[i].k);
      check($sformatf("vec%0d_ready", i), {15'd0, bus.ev_ready}, {15'd0, vecs[i].r});
    end
    drive(1'b0, 1'b0, 8'h00);
    idle_until(load_e + HOLD, 16'h0041, "t1_hold");
    tick();
    check("t1_release", key_out, 16'h0000);

    // Rollover: 0x42 replaces 0x41 once hold is met; stale release discarded
    push(1'b1, 8'h41);
    tick();
    check("t3_load41", key_out, 16'h0041);
    load_e = edge_n;
    push(1'b1, 8'h42);
    check("t3_wait", key_out, 16'h0041);
    idle_until(load_e + HOLD, 16'h0041, "t3_hold41");
    tick();
    check("t3_roll42", key_out, 16'h0042);
    load2_e = edge_n;
    push(1'b0, 8'h41);
    check("t3_rel41a", key_out, 16'h0042);
    tick();
    check("t3_rel41b", key_out, 16'h0042);
    push(1'b0, 8'h42);
    idle_until(load2_e + HOLD, 16'h0042, "t3_hold42");
    tick();
    check("t3_rel42", key_out, 16'h0000);

    // Typematic repeat does not restart the hold counter
    push(1'b1, 8'h41);
    tick();
    load_e = edge_n;
    check("t4_load", key_out, 16'h0041);
    for (int r = 0; r < 3; r++) begin
      push(1'b1, 8'h41);
      check("t4_rep", key_out, 16'h0041);
      tick();
      tick();
      check("t4_rep_ready", {15'd0, bus.ev_ready}, 16'h0001);
    end
    push(1'b0, 8'h41);
    idle_until(load_e + HOLD, 16'h0041, "t4_hold");
    tick();
    check("t4_release", key_out, 16'h0000);

    // Blocking head with DEPTH+1 events offered back to back
    push(1'b1, 8'h41);
    tick();
    load_e = edge_n;
    ev5_press[0] = 1'b0; ev5_code[0] = 8'h41; ev5_exp[0] = load_e + 1;
    ev5_press[1] = 1'b1; ev5_code[1] = 8'h50; ev5_exp[1] = load_e + 2;
    ev5_press[2] = 1'b1; ev5_code[2] = 8'h51; ev5_exp[2] = load_e + 3;
    ev5_press[3] = 1'b1; ev5_code[3] = 8'h52; ev5_exp[3] = load_e + 4;
    ev5_press[4] = 1'b1; ev5_code[4] = 8'h53; ev5_exp[4] = load_e + HOLD + 2;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ev5_press[k], ev5_code[k]);
      acc_e = -1;
      for (int w = 0; w < 40; w++) begin
        acc = bus.ev_ready;
        tick();
        if (edge_n == load_e + 4)
          check("t5_full", {15'd0, bus.ev_ready}, 16'h0000);
`ifdef KBD_OVF_EN
        if (edge_n == load_e + 5)
          check("t5_ovf_set", {15'd0, ovf}, 16'h0001);
`endif
        if (edge_n == load_e + HOLD + 1)
          check("t5_release", key_out, 16'h0000);
        if (acc) begin
          acc_e = edge_n;
          break;
        end
      end
      check($sformatf("t5_accept%0d", k), 16'(acc_e), 16'(ev5_exp[k]));
    end
    drive(1'b0, 1'b0, 8'h00);
    check("t5_key50", key_out, 16'h0050);
`ifdef KBD_OVF_EN
    check("t5_ovf_hold", {15'd0, ovf}, 16'h0001);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t5_ovf_clr", {15'd0, ovf}, 16'h0000);
`endif
    check("t6_pre_key", key_out, 16'h0050);

    // Asynchronous reset mid-HELD with three entries queued
    #3 reset = 1'b1;
    #1;
    check("t6_async_key", key_out, 16'h0000);
    check("t6_async_ready", {15'd0, bus.ev_ready}, 16'h0001);
    tick();
    check("t6_in_reset", key_out, 16'h0000);
    #2 reset = 1'b0;
    tick();
    check("t6_post_idle", key_out, 16'h0000);
    push(1'b1, 8'h0D);
    check("t6_accept", key_out, 16'h0000);
    tick();
    check("t6_key0d", key_out, 16'h000D);
    idle_until(edge_n + 3, 16'h000D, "t6_stay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
